// File: rtl/cond_unit.sv
// ============================================================================
//  Module      : cond_unit
//  Description : Condition-evaluation stage: holds the architectural {N,Z,C,V}
//                flags, gates PCSrc/RegWrite/MemWrite per instruction and
//                commits ALU flags, as a single valid/ready pipeline stage.
//                Optional statistics counters enabled by `define COND_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_unit #(
    parameter int unsigned CNT_W       = 8,
    parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       cond,
    input  logic [1:0]       flag_write,
    input  logic [3:0]       alu_flags,
    input  logic             pcs_in,
    input  logic             reg_w_in,
    input  logic             mem_w_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             cond_ex,
    output logic             pcsrc,
    output logic             reg_write,
    output logic             mem_write,
    output logic [3:0]       flags
`ifdef COND_STATS_EN
    ,
    output logic [CNT_W-1:0] exec_count,
    output logic [CNT_W-1:0] squash_count
`endif
);

    logic       r_out_valid;
    logic       r_cond_ex;
    logic       r_pcsrc;
    logic       r_reg_write;
    logic       r_mem_write;
    logic [3:0] r_flags;
    logic       w_accept;
    logic       w_pass;
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;

    assign {w_n, w_z, w_c, w_v} = r_flags;
    assign in_ready = ~r_out_valid | out_ready;
    assign w_accept = in_valid & in_ready;

    // Condition is judged against the flags as they stand before this instruction commits.
    always_comb begin
        w_pass = 1'b1;
        case (cond)
            4'h0:    w_pass = w_z;
            4'h1:    w_pass = ~w_z;
            4'h2:    w_pass = w_c;
            4'h3:    w_pass = ~w_c;
            4'h4:    w_pass = w_n;
            4'h5:    w_pass = ~w_n;
            4'h6:    w_pass = w_v;
            4'h7:    w_pass = ~w_v;
            4'h8:    w_pass = w_c & ~w_z;
            4'h9:    w_pass = ~w_c | w_z;
            4'hA:    w_pass = (w_n == w_v);
            4'hB:    w_pass = (w_n != w_v);
            4'hC:    w_pass = ~w_z & (w_n == w_v);
            4'hD:    w_pass = w_z | (w_n != w_v);
            default: w_pass = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags     <= RESET_FLAGS;
            r_out_valid <= 1'b0;
            r_cond_ex   <= 1'b0;
            r_pcsrc     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_cond_ex   <= w_pass;
            r_pcsrc     <= pcs_in & w_pass;
            r_reg_write <= reg_w_in & w_pass;
            r_mem_write <= mem_w_in & w_pass;
            if (w_pass && flag_write[1]) begin
                r_flags[3:2] <= alu_flags[3:2];
            end
            if (w_pass && flag_write[0]) begin
                r_flags[1:0] <= alu_flags[1:0];
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_cond_ex   <= 1'b0;
            r_pcsrc     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_write <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign cond_ex   = r_cond_ex;
    assign pcsrc     = r_pcsrc;
    assign reg_write = r_reg_write;
    assign mem_write = r_mem_write;
    assign flags     = r_flags;

`ifdef COND_STATS_EN
    logic [CNT_W-1:0] r_exec_cnt;
    logic [CNT_W-1:0] r_squash_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exec_cnt   <= '0;
            r_squash_cnt <= '0;
        end else if (w_accept) begin
            if (w_pass) begin
                r_exec_cnt <= r_exec_cnt + 1'b1;
            end else begin
                r_squash_cnt <= r_squash_cnt + 1'b1;
            end
        end
    end

    assign exec_count   = r_exec_cnt;
    assign squash_count = r_squash_cnt;
`else
    // Counter width is still validated so both builds accept the same parameter set.
    generate
        if (CNT_W == 0) begin : g_cnt_w_check
            $error("cond_unit: CNT_W must be nonzero");
        end
    endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_cond_unit.sv
// ============================================================================
//  Module      : tb_cond_unit
//  Description : Self-checking bench for cond_unit: directed scenarios with
//                literal expectations plus randomized traffic against a model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cond_unit;

    localparam int unsigned CNT_W = 8;
    localparam logic [3:0]  RESET_FLAGS = 4'b0000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] cond = 4'h0;
    logic [1:0] flag_write = 2'b00;
    logic [3:0] alu_flags = 4'h0;
    logic       pcs_in = 1'b0;
    logic       reg_w_in = 1'b0;
    logic       mem_w_in = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       cond_ex;
    logic       pcsrc;
    logic       reg_write;
    logic       mem_write;
    logic [3:0] flags;
`ifdef COND_STATS_EN
    logic [CNT_W-1:0] exec_count;
    logic [CNT_W-1:0] squash_count;
`endif

    int checks = 0;
    int failures = 0;

    cond_unit #(.CNT_W(CNT_W), .RESET_FLAGS(RESET_FLAGS)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .cond(cond), .flag_write(flag_write), .alu_flags(alu_flags),
        .pcs_in(pcs_in), .reg_w_in(reg_w_in), .mem_w_in(mem_w_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .cond_ex(cond_ex), .pcsrc(pcsrc), .reg_write(reg_write),
        .mem_write(mem_write), .flags(flags)
`ifdef COND_STATS_EN
        , .exec_count(exec_count), .squash_count(squash_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural rule: cond[3:1] picks a base predicate, cond[0] inverts it; 7 is always.
    function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, base;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    // Reference model of the stage
    logic [3:0] m_flags = RESET_FLAGS;
    bit m_valid, m_cex, m_pcs, m_rw, m_mw;
    int unsigned m_exec = 0, m_squash = 0;

    always @(posedge clk or posedge reset) begin
        bit acc, p;
        if (reset) begin
            m_flags = RESET_FLAGS;
            {m_valid, m_cex, m_pcs, m_rw, m_mw} = '0;
            m_exec = 0;
            m_squash = 0;
        end else begin
            acc = in_valid && (!m_valid || out_ready);
            if (acc) begin
                p = cond_pass(cond, m_flags);
                m_valid = 1;
                m_cex = p;
                m_pcs = pcs_in && p;
                m_rw = reg_w_in && p;
                m_mw = mem_w_in && p;
                if (p) begin
                    m_exec++;
                    if (flag_write[1]) m_flags[3:2] = alu_flags[3:2];
                    if (flag_write[0]) m_flags[1:0] = alu_flags[1:0];
                end else begin
                    m_squash++;
                end
            end else if (out_ready) begin
                {m_valid, m_cex, m_pcs, m_rw, m_mw} = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("cmp_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
            chk("cmp_in_ready", {31'b0, in_ready}, {31'b0, (!m_valid || out_ready)});
            chk("cmp_flags", {28'b0, flags}, {28'b0, m_flags});
            chk("cmp_gated", {29'b0, pcsrc, reg_write, mem_write}, {29'b0, m_pcs, m_rw, m_mw});
            if (m_valid) chk("cmp_cond_ex", {31'b0, cond_ex}, {31'b0, m_cex});
`ifdef COND_STATS_EN
            chk("cmp_exec_count", {{(32-CNT_W){1'b0}}, exec_count}, m_exec % (1 << CNT_W));
            chk("cmp_squash_count", {{(32-CNT_W){1'b0}}, squash_count}, m_squash % (1 << CNT_W));
`endif
        end
    end

    // Inputs are applied 3 time units after an edge and consumed by the next edge.
    task automatic drive(input bit iv, input logic [3:0] c, input logic [1:0] fw,
                         input logic [3:0] af, input bit p, input bit rw, input bit mw,
                         input bit ordy);
        in_valid = iv; cond = c; flag_write = fw; alu_flags = af;
        pcs_in = p; reg_w_in = rw; mem_w_in = mw; out_ready = ordy;
        @(posedge clk);
        #3;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        chk("reset_flags", {28'b0, flags}, 32'h0);
        chk("reset_out_valid", {31'b0, out_valid}, 32'h0);

        drive(1, 4'hE, 2'b00, 4'h0, 0, 1, 0, 1);
        chk("al_valid", {31'b0, out_valid}, 32'h1);
        chk("al_cond_ex", {31'b0, cond_ex}, 32'h1);
        chk("al_reg_write", {31'b0, reg_write}, 32'h1);

        drive(1, 4'hE, 2'b11, 4'b0100, 0, 0, 0, 1);
        chk("commit_flags", {28'b0, flags}, 32'h4);
        drive(1, 4'h0, 2'b00, 4'h0, 1, 0, 0, 1);
        chk("eq_cond_ex", {31'b0, cond_ex}, 32'h1);
        chk("eq_pcsrc", {31'b0, pcsrc}, 32'h1);
        drive(1, 4'h1, 2'b00, 4'h0, 1, 0, 0, 1);
        chk("ne_cond_ex", {31'b0, cond_ex}, 32'h0);
        chk("ne_pcsrc", {31'b0, pcsrc}, 32'h0);
        drive(1, 4'h1, 2'b11, 4'b1010, 0, 1, 1, 1);
        chk("squash_cond_ex", {31'b0, cond_ex}, 32'h0);
        chk("squash_flags", {28'b0, flags}, 32'h4);

        drive(1, 4'hE, 2'b11, 4'b1111, 0, 0, 0, 1);
        chk("set_all_flags", {28'b0, flags}, 32'hF);
        drive(1, 4'hE, 2'b01, 4'b0000, 0, 0, 0, 1);
        chk("partial_flags", {28'b0, flags}, 32'hC);

        // flags = N=1 Z=1 C=0 V=0
        drive(1, 4'hA, 2'b00, 4'h0, 0, 0, 0, 1);
        chk("ge_fail", {31'b0, cond_ex}, 32'h0);
        drive(1, 4'hB, 2'b00, 4'h0, 0, 0, 0, 1);
        chk("lt_pass", {31'b0, cond_ex}, 32'h1);
        drive(1, 4'hC, 2'b00, 4'h0, 0, 0, 0, 1);
        chk("gt_fail", {31'b0, cond_ex}, 32'h0);
        drive(1, 4'hD, 2'b00, 4'h0, 0, 0, 0, 1);
        chk("le_pass", {31'b0, cond_ex}, 32'h1);
        drive(1, 4'h8, 2'b00, 4'h0, 0, 0, 0, 1);
        chk("hi_fail", {31'b0, cond_ex}, 32'h0);
        drive(1, 4'h9, 2'b00, 4'h0, 0, 1, 0, 1);
        chk("ls_pass", {31'b0, reg_write}, 32'h1);

        // Backpressure: output held while out_ready is low.
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'h0, 2'b11, 4'b0000, 0, 0, 1, 0);
            chk("stall_in_ready", {31'b0, in_ready}, 32'h0);
            chk("stall_out_valid", {31'b0, out_valid}, 32'h1);
            chk("stall_reg_write", {31'b0, reg_write}, 32'h1);
            chk("stall_flags", {28'b0, flags}, 32'hC);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", {31'b0, in_ready}, 32'h1);
        @(posedge clk);
        #3;
        chk("release_mem_write", {31'b0, mem_write}, 32'h1);
        chk("release_flags", {28'b0, flags}, 32'h0);

        drive(1, 4'hE, 2'b11, 4'b1011, 0, 0, 0, 1);
        chk("pre_reset_flags", {28'b0, flags}, 32'hB);
        drive(1, 4'hE, 2'b11, 4'b0110, 0, 0, 0, 0);
        drive(1, 4'hE, 2'b11, 4'b0110, 0, 0, 0, 0);
        chk("stall2_flags", {28'b0, flags}, 32'hB);
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset_valid", {31'b0, out_valid}, 32'h0);
        chk("async_reset_flags", {28'b0, flags}, {28'b0, RESET_FLAGS});
        @(posedge clk);
        #3;
        reset = 1'b0;

        // Randomized traffic; the negedge compare process checks every cycle.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom), 2'($urandom), 4'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
        end
        drive(0, 4'h0, 2'b00, 4'h0, 0, 0, 0, 1);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
